ring_scan_driver: RTL and testbench
===================================

# ring_scan_driver

- Display scan stage that sits directly downstream of the 4-bit ring counter.
- Consumes the ring's one-hot phase vector and steps through four hex digits. Drives a registered digit enable and the 7-segment code for the selected digit.
- Inserts dead-time blanking on every phase change.
- Detects illegal ring codes (multi-hot, or zero after start-up), blanks the display while one is present, and counts each fault.

## Interface
Parameters:
- DEAD_CYCLES, default 2: blanking cycles inserted after each legal phase change; legal range 0..15.
- ERR_W, default 8: width of the saturating fault counter; legal range 1..16.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset; one clock, async active-low reset.
- phase  input  4  one-hot ring phase from the ring counter; phase[i] selects digit i.
- digits  input  16  digit i = digits[4i+3:4i], hex value; sampled live while driving.
- err_clr  input  1  synchronous clear of err_cnt.
- an  output  4  registered active-high digit enable, one-hot or zero.
- seg  output  7  registered active-high segments {g,f,e,d,c,b,a}.
- fault  output  1  registered; high while in FAULT.
- err_cnt  output  ERR_W  saturating count of FAULT entries.

## Operation
- Input register: phase_q <= phase every cycle. The FSM acts only on phase_q.
- legal(phase_q) means exactly one bit is set.
- sel_q latches the phase being driven. dcnt is a 4-bit dead-time down-counter.
- Reset state: BLANK. phase_q, sel_q, an, seg, dcnt and err_cnt all = 0; fault = 0.
- FSM states and transitions (evaluated on phase_q):
  - BLANK:
    - phase_q == 0: stay. An unseeded or still-zero ring is not a fault here.
    - legal: load sel_q and go to DEAD (dcnt = DEAD_CYCLES), or directly to DRIVE if DEAD_CYCLES = 0.
    - multi-hot: go to FAULT.
  - DEAD:
    - an = 0, seg = 0. dcnt decrements each cycle; go to DRIVE on the cycle dcnt reaches 1.
    - phase_q legal and != sel_q: reload sel_q and dcnt (restart dead-time).
    - phase_q illegal (including zero): go to FAULT.
  - DRIVE:
    - an = sel_q; seg = hex7(digits[sel_q]), updated every cycle.
    - phase_q == sel_q: stay.
    - legal and != sel_q: reload sel_q and go to DEAD, or stay in DRIVE with the new sel_q if DEAD_CYCLES = 0.
    - illegal: go to FAULT.
  - FAULT:
    - an = 0, seg = 0, fault = 1.
    - phase_q legal: load sel_q and go to DEAD (or DRIVE if DEAD_CYCLES = 0).
    - Otherwise stay, including when phase_q == 0.
- err_cnt:
  - Increments by 1 on each transition into FAULT, not on cycles spent staying in FAULT.
  - Saturates at all-ones.
  - err_clr sets it to 0; on the same cycle as an increment, clear wins and the result is 0.
- hex7 encoding (seg = {g,f,e,d,c,b,a}):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07
  - 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71
- an and seg are registered from next-state values, so they always agree with state.
- an and fault are never active together.

## Timing
- Phase change latency:
  - phase changes before edge k; phase_q updates at edge k; state and outputs update at edge k+1.
  - an goes to 0 at edge k+1.
  - The new an is asserted at edge k+1+DEAD_CYCLES.
- DEAD_CYCLES = 0: an switches old to new at edge k+1 with no zero gap.
- Digit data latency: a change on digits reaches seg 1 cycle later, while in DRIVE.
- Fault latency:
  - Illegal phase before edge k gives fault = 1, an = 0 and the err_cnt increment at edge k+1.
  - Recovery: the first legal phase_q enters DEAD at the next edge.
- Ring advancing faster than DEAD_CYCLES+1: the dead-time restarts on every change and an stays 0. This is the required behaviour; the ring must be enabled slowly.
- Async reset assertion:
  - Clears all state and outputs immediately, mid-DEAD or mid-FAULT included.
  - Release is synchronous to the next edge; the block restarts in BLANK.

## Test plan
- Reset, phase = 0000 for 10 cycles: an = 0, seg = 0, fault = 0, err_cnt = 0 throughout; state stays BLANK.
- DEAD_CYCLES = 2, digits = 0x4321, phase held 0001 then 0010:
  - an = 0001, seg = 0x06 after 1+2 cycles;
  - on the change to 0010, exactly 2 cycles of an = 0, then an = 0010, seg = 0x5B.
- DEAD_CYCLES = 0, ring rotating every cycle over 0001..1000 with digits = 0xF8A0: an follows phase_q with no gap, and seg cycles 0x3F, 0x77, 0x7F, 0x71.
- Multi-hot then zero then legal (DRIVE, then 0110 for 3 cycles, 0000 for 2 cycles, then 0100):
  - fault = 1 and an = 0 for 5 cycles; err_cnt = 1, counted once;
  - recovery goes through DEAD to an = 0100.
- ERR_W = 2, five separate FAULT entries: err_cnt = 1, 2, 3, 3, 3. err_clr asserted on the same cycle as a sixth entry: err_cnt = 0.
- Reset asserted mid-DEAD and mid-FAULT: an, seg, fault and err_cnt = 0 asynchronously, before the next edge; normal sequencing resumes after release.

Source files
------------

// File: rtl/ring_scan_driver.sv
// ring_scan_driver: display scan stage fed by a 4-bit one-hot ring counter.
// Selects one of four hex digits from the ring phase, inserts dead-time
// blanking on each phase change, and blanks plus counts illegal ring codes.
module ring_scan_driver #(
    parameter int unsigned DEAD_CYCLES = 2,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       phase,
    input  logic [15:0]      digits,
    input  logic             err_clr,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             fault,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned PH_W   = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DCNT_W = 4;

    localparam logic [DCNT_W-1:0] DEAD_INIT = DCNT_W'(DEAD_CYCLES);
    localparam logic              NO_DEAD   = (DEAD_CYCLES == 0);
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_DEAD  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [PH_W-1:0]     phase_q;
    logic [PH_W-1:0]     sel_q, sel_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [PH_W-1:0]     an_q, an_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic                fault_q, fault_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                phase_legal;
    logic                fault_entry;

    // Exactly one bit set.
    function automatic logic is_onehot(input logic [PH_W-1:0] p);
        return (p != PH_W'(0)) && ((p & (p - PH_W'(1))) == PH_W'(0));
    endfunction

    // Hex digit to active-high segments {g,f,e,d,c,b,a}.
    function automatic logic [SEG_W-1:0] hex7(input logic [3:0] v);
        logic [SEG_W-1:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Nibble of the digit word picked by a one-hot select.
    function automatic logic [3:0] pick_digit(input logic [PH_W-1:0] sel,
                                              input logic [15:0]     dig);
        logic [3:0] d;
        case (sel)
            4'b0001: d = dig[3:0];
            4'b0010: d = dig[7:4];
            4'b0100: d = dig[11:8];
            4'b1000: d = dig[15:12];
            default: d = 4'h0;
        endcase
        return d;
    endfunction

    assign phase_legal = is_onehot(phase_q);

    // Input register: the FSM only ever looks at the registered phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase;
        end
    end

    // Next-state, dead-time counter and output decode.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        dcnt_d      = dcnt_q;
        an_d        = '0;
        seg_d       = '0;
        fault_d     = 1'b0;
        err_d       = err_q;
        fault_entry = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (phase_legal) begin
                    sel_d = phase_q;
                    if (NO_DEAD) begin
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_DEAD;
                        dcnt_d  = DEAD_INIT;
                    end
                end else if (phase_q != PH_W'(0)) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DEAD: begin
                if (!phase_legal) begin
                    state_d = ST_FAULT;
                end else if (phase_q != sel_q) begin
                    // New phase mid-blanking: restart the dead time.
                    sel_d  = phase_q;
                    dcnt_d = DEAD_INIT;
                end else if (dcnt_q <= DCNT_W'(1)) begin
                    state_d = ST_DRIVE;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q - DCNT_W'(1);
                end
            end
            ST_DRIVE: begin
                if (!phase_legal) begin
                    state_d = ST_FAULT;
                end else if (phase_q != sel_q) begin
                    sel_d = phase_q;
                    if (!NO_DEAD) begin
                        state_d = ST_DEAD;
                        dcnt_d  = DEAD_INIT;
                    end
                end
            end
            ST_FAULT: begin
                if (phase_legal) begin
                    sel_d = phase_q;
                    if (NO_DEAD) begin
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_DEAD;
                        dcnt_d  = DEAD_INIT;
                    end
                end
            end
            default: begin
                state_d = ST_BLANK;
                sel_d   = '0;
                dcnt_d  = '0;
            end
        endcase

        if (state_d == ST_FAULT) begin
            dcnt_d = '0;
        end

        // Outputs follow the next state so they never lag the FSM.
        if (state_d == ST_DRIVE) begin
            an_d  = sel_d;
            seg_d = hex7(pick_digit(sel_d, digits));
        end
        fault_d = (state_d == ST_FAULT);

        // Count entries into FAULT only; clear has priority.
        fault_entry = (state_d == ST_FAULT) && (state_q != ST_FAULT);
        if (err_clr) begin
            err_d = '0;
        end else if (fault_entry && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    // State, select, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BLANK;
            sel_q   <= '0;
            dcnt_q  <= '0;
            an_q    <= '0;
            seg_q   <= '0;
            fault_q <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dcnt_q  <= dcnt_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            fault_q <= fault_d;
            err_q   <= err_d;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign fault   = fault_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_ring_scan_driver.sv
// Bench for ring_scan_driver: two instances (DEAD_CYCLES=2/ERR_W=2 and
// DEAD_CYCLES=0/ERR_W=8) share the same stimulus. A history-based model
// derives the expected outputs; directed literal checks pin the model.
module tb_ring_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  phase;
    logic [15:0] digits;
    logic        err_clr;

    logic [3:0]  an2, an0;
    logic [6:0]  seg2, seg0;
    logic        f2, f0;
    logic [1:0]  err2;
    logic [7:0]  err0;

    ring_scan_driver #(.DEAD_CYCLES(2), .ERR_W(2)) u_d2 (
        .clk(clk), .reset(reset), .phase(phase), .digits(digits),
        .err_clr(err_clr), .an(an2), .seg(seg2), .fault(f2), .err_cnt(err2)
    );

    ring_scan_driver #(.DEAD_CYCLES(0), .ERR_W(8)) u_d0 (
        .clk(clk), .reset(reset), .phase(phase), .digits(digits),
        .err_clr(err_clr), .an(an0), .seg(seg0), .fault(f0), .err_cnt(err0)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    localparam int DC     [2] = '{2, 0};
    localparam int ERRMAX [2] = '{3, 255};

    int  n_vec  = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;

    // Registered-phase samples since the last reset (reset value first).
    logic [3:0] hist [$];
    logic [3:0] exp_an    [2];
    logic [6:0] exp_seg   [2];
    bit         exp_fault [2];
    int         exp_err   [2];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit legal(input logic [3:0] p);
        return $countones(p) == 1;
    endfunction

    // A digit is lit once the same legal phase has been seen for d+1 samples.
    function automatic logic [3:0] win_an(input int d);
        logic [3:0] p;
        if (hist.size() < d + 1) return 4'b0;
        p = hist[hist.size()-1];
        if (!legal(p)) return 4'b0;
        for (int i = 1; i <= d; i++)
            if (hist[hist.size()-1-i] != p) return 4'b0;
        return p;
    endfunction

    // Faulted: every sample since the last legal one is illegal (at least one);
    // with no legal sample yet, only a multi-hot code counts.
    function automatic bit hist_fault();
        bit multi;
        multi = 1'b0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (legal(hist[i])) return (i != hist.size() - 1);
            if (hist[i] != 4'b0) multi = 1'b1;
        end
        return multi;
    endfunction

    function automatic logic [6:0] seg_for(input logic [3:0] a, input logic [15:0] dg);
        for (int i = 0; i < 4; i++)
            if (a[i]) return HEX[dg[4*i +: 4]];
        return 7'h00;
    endfunction

    // Behavioural model, updated on each active edge or async reset.
    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            hist.delete();
            hist.push_back(4'b0);
            for (int k = 0; k < 2; k++) begin
                exp_an[k] = 4'b0; exp_seg[k] = 7'h0; exp_fault[k] = 1'b0; exp_err[k] = 0;
            end
        end else begin
            bit f;
            f = hist_fault();
            for (int k = 0; k < 2; k++) begin
                bit entry;
                entry = f && !exp_fault[k];
                exp_an[k]  = win_an(DC[k]);
                exp_seg[k] = seg_for(exp_an[k], digits);
                if (err_clr) exp_err[k] = 0;
                else if (entry && exp_err[k] < ERRMAX[k]) exp_err[k]++;
                exp_fault[k] = f;
            end
            hist.push_back(phase);
        end
    end

    // Every-cycle compare against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp("m_an_d2",    32'(an2),  32'(exp_an[0]));
            cmp("m_seg_d2",   32'(seg2), 32'(exp_seg[0]));
            cmp("m_fault_d2", 32'(f2),   32'(exp_fault[0]));
            cmp("m_err_d2",   32'(err2), 32'(exp_err[0]));
            cmp("m_an_d0",    32'(an0),  32'(exp_an[1]));
            cmp("m_seg_d0",   32'(seg0), 32'(exp_seg[1]));
            cmp("m_fault_d0", 32'(f0),   32'(exp_fault[1]));
            cmp("m_err_d0",   32'(err0), 32'(exp_err[1]));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    localparam logic [3:0] ROT    [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    localparam logic [6:0] ROTSEG [4] = '{7'h3F, 7'h77, 7'h7F, 7'h71};
    localparam int         SATSEQ [5] = '{1, 2, 3, 3, 3};

    initial begin
        reset = 1'b1; phase = 4'b0; digits = 16'h0; err_clr = 1'b0;
        #1 reset = 1'b0;
        chk_en = 1'b1;
        tick(); tick();
        reset = 1'b1;

        // Idle with a zero ring: nothing lit, no fault.
        for (int i = 0; i < 10; i++) begin
            tick();
            cmp("idle_an",    32'(an2), 32'h0);
            cmp("idle_fault", 32'(f2),  32'h0);
            cmp("idle_err",   32'(err2), 32'h0);
        end

        // Start-up and one phase change.
        digits = 16'h4321; phase = 4'b0001;
        tick(); cmp("su_an_d2_1", 32'(an2), 32'h0);
        tick(); cmp("su_an_d2_2", 32'(an2), 32'h0);
                cmp("su_an_d0",   32'(an0), 32'h1);
                cmp("su_seg_d0",  32'(seg0), 32'h06);
        tick(); cmp("su_an_d2_3", 32'(an2), 32'h0);
        tick(); cmp("su_an_d2",   32'(an2), 32'h1);
                cmp("su_seg_d2",  32'(seg2), 32'h06);
        tick(); tick();
        phase = 4'b0010;
        tick(); cmp("chg_old_an", 32'(an2), 32'h1);
        tick(); cmp("chg_gap1",   32'(an2), 32'h0);
                cmp("chg_an_d0",  32'(an0), 32'h2);
                cmp("chg_seg_d0", 32'(seg0), 32'h5B);
        tick(); cmp("chg_gap2",   32'(an2), 32'h0);
        tick(); cmp("chg_an_d2",  32'(an2), 32'h2);
                cmp("chg_seg_d2", 32'(seg2), 32'h5B);
        digits = 16'h4371;
        tick(); cmp("dig_lat_seg", 32'(seg2), 32'h07);

        // Fast rotation: d0 follows with no gap, d2 stays dark.
        digits = 16'hF8A0;
        for (int i = 0; i < 8; i++) begin
            phase = ROT[i % 4];
            tick();
            if (i >= 1) begin
                cmp("rot_an_d0",  32'(an0),  32'(ROT[(i-1) % 4]));
                cmp("rot_seg_d0", 32'(seg0), 32'(ROTSEG[(i-1) % 4]));
                cmp("rot_an_d2",  32'(an2),  32'h0);
            end
        end
        tick(); tick(); tick(); tick();
        cmp("rot_settle_d2", 32'(an2), 32'h8);
        cmp("rot_settle_seg", 32'(seg2), 32'h71);

        // Multi-hot, then zero, then legal recovery.
        phase = 4'b0110;
        tick(); cmp("mh_pre_fault", 32'(f2), 32'h0);
        tick(); cmp("mh_fault_1", 32'(f2), 32'h1); cmp("mh_an_1", 32'(an2), 32'h0);
        tick(); phase = 4'b0000;
                cmp("mh_fault_2", 32'(f2), 32'h1);
        tick(); cmp("mh_fault_3", 32'(f0), 32'h1); cmp("mh_an_3", 32'(an0), 32'h0);
        tick(); phase = 4'b0100;
                cmp("mh_fault_4", 32'(f2), 32'h1);
        tick(); cmp("mh_fault_5", 32'(f2), 32'h1);
                cmp("mh_err_d2", 32'(err2), 32'h1);
                cmp("mh_err_d0", 32'(err0), 32'h1);
        tick(); cmp("rec_fault", 32'(f2), 32'h0); cmp("rec_dead_an", 32'(an2), 32'h0);
                cmp("rec_an_d0", 32'(an0), 32'h4); cmp("rec_seg_d0", 32'(seg0), 32'h7F);
        tick(); cmp("rec_dead_an2", 32'(an2), 32'h0);
        tick(); cmp("rec_an_d2", 32'(an2), 32'h4); cmp("rec_seg_d2", 32'(seg2), 32'h7F);

        // Saturation of the narrow counter over five entries.
        err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        cmp("clr_err_d2", 32'(err2), 32'h0);
        cmp("clr_err_d0", 32'(err0), 32'h0);
        for (int e = 0; e < 5; e++) begin
            phase = 4'b0011;
            tick(); tick();
            cmp("sat_err_d2", 32'(err2), 32'(SATSEQ[e]));
            cmp("sat_err_d0", 32'(err0), 32'(e + 1));
            phase = 4'b0001;
            tick(); tick();
        end
        phase = 4'b0011;
        tick(); err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        cmp("clrwin_err_d2", 32'(err2), 32'h0);
        cmp("clrwin_err_d0", 32'(err0), 32'h0);
        tick(); cmp("clrwin_hold_d2", 32'(err2), 32'h0);
        phase = 4'b0001;
        tick(); tick(); tick(); tick();
        cmp("post_clr_an", 32'(an2), 32'h1);

        // Async reset in the middle of FAULT.
        phase = 4'b1111;
        tick(); tick();
        cmp("rf_fault", 32'(f2), 32'h1);
        #2 reset = 1'b0;
        #1 cmp("rf_async_fault", 32'(f2), 32'h0);
        cmp("rf_async_err_d2", 32'(err2), 32'h0);
        cmp("rf_async_err_d0", 32'(err0), 32'h0);
        cmp("rf_async_fault_d0", 32'(f0), 32'h0);
        phase = 4'b0000;
        tick(); reset = 1'b1;
        tick(); tick();
        phase = 4'b0001;
        tick(); tick(); tick(); tick();
        cmp("rf_resume_an", 32'(an2), 32'h1);

        // Async reset in the middle of DEAD.
        phase = 4'b0100;
        tick(); tick();
        cmp("rd_an_d0", 32'(an0), 32'h4);
        #2 reset = 1'b0;
        #1 cmp("rd_async_an_d0", 32'(an0), 32'h0);
        cmp("rd_async_seg_d0", 32'(seg0), 32'h0);
        cmp("rd_async_an_d2", 32'(an2), 32'h0);
        tick(); reset = 1'b1;
        tick(); cmp("rd_blank_an_d0", 32'(an0), 32'h0);
        tick(); cmp("rd_resume_d0", 32'(an0), 32'h4);
        tick(); cmp("rd_dead_d2", 32'(an2), 32'h0);
        tick(); cmp("rd_resume_d2", 32'(an2), 32'h4);
                cmp("rd_resume_seg", 32'(seg2), 32'h7F);

        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
